// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
//   fetch_state_t : FSM encoding (FETCH=0, STALL=1, HALT=2), also exported on fetch_state
//   fetch_entry_t : one queue entry, {pc, inst}
//   PC_STEP       : byte increment between sequential fetches
//   RESET_PC_DEF  : default byte PC loaded on reset
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Fetch-side buses of rom_fetch_ctrl.
//   rom_addr/rom_data                     : asynchronous-read instruction ROM port
//   inst_valid/inst_ready/inst_data/inst_pc : valid/ready handshake towards decode
// master = the fetch controller, slave = ROM plus decode.
interface rom_fetch_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [31:0]       inst_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue of fetch_entry_t.
//   clk, rst      : clock, synchronous active-high reset (empties the queue)
//   push, wdata   : enqueue; accepted when not full, or when full with a pop in the same cycle
//   pop, rdata    : dequeue the head; rdata reads as 0 while empty
//   flush         : discard all entries at the edge
//   full, empty, count : occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Empty queue presents zeros so decode never sees stale or unknown data.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer in front of an asynchronous-read ROM.
//   CLK, RESET        : clock, synchronous active-high reset
//   bus (master)      : ROM address/data and the decode valid/ready handshake
//   redirect_valid/pc : single-cycle branch/jump redirect to a byte address
//   halt              : level; suppresses new fetches while high
//   fetch_state       : current FSM state (FETCH/STALL/HALT)
// Owns the pc, fetches one word per cycle into fetch_queue whenever it has
// room, and absorbs stalls, redirects and halt. Priority: RESET > redirect >
// halt > normal push/pop.
module rom_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    rom_fetch_ctrl_if.master        bus,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic                    halt,
    output logic [1:0]              fetch_state
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              pop;
    logic              space;
    logic              push;
    logic              q_pop;
    logic              flush;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_wdata;
    fetch_entry_t      q_rdata;
    logic              unused_pc_lsb;

    // Redirect targets are word aligned; the low bits are dropped.
    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign pop   = bus.inst_valid & bus.inst_ready;
    assign space = ~q_full | pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        q_pop   = pop;
        flush   = 1'b0;
        if (redirect_valid) begin
            // The head being presented this cycle is killed, not consumed.
            flush   = 1'b1;
            q_pop   = 1'b0;
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = halt ? HALT : FETCH;
        end else if (halt) begin
            state_d = HALT;
        end else begin
            // FETCH, STALL and HALT-with-halt-released all behave alike here:
            // fetch whenever the queue can take the word, and park in STALL
            // once it fills up with decode not consuming.
            push = space;
            if (push) pc_d = pc_q + PC_STEP;
            if (!pop && (q_full || (push && q_count == CNT_W'(QDEPTH - 1))))
                state_d = STALL;
            else
                state_d = FETCH;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign q_wdata = '{pc: pc_q, inst: 32'(bus.rom_data)};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (q_pop),
        .flush (flush),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Only the low word-address bits reach the ROM, so fetch wraps the ROM
    // while inst_pc keeps the full byte address.
    assign bus.rom_addr   = pc_q[ADDR_W+1:2];
    assign bus.inst_valid = ~q_empty;
    assign bus.inst_data  = DATA_W'(q_rdata.inst);
    assign bus.inst_pc    = q_rdata.pc;
    assign fetch_state    = state_q;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
module tb_rom_fetch_ctrl;
    import fetch_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [1:0]  fetch_state;

    rom_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [31:0] rom [1024];
    assign bus.rom_data = rom[bus.rom_addr];

    rom_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_state    (fetch_state)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Program image: word i holds C0DE_0000 | i.
    function automatic logic [31:0] img(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input int word);
        check({tag, ".valid"}, 64'(bus.inst_valid), 64'd1);
        check({tag, ".pc"},    64'(bus.inst_pc),    64'(pc));
        check({tag, ".data"},  64'(bus.inst_data),  64'(img(word)));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = img(i);
        RESET          = 1'b1;
        bus.inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        tick();
        tick();

        check("rst.valid", 64'(bus.inst_valid), 64'd0);
        check("rst.data",  64'(bus.inst_data),  64'd0);
        check("rst.pc",    64'(bus.inst_pc),    64'd0);
        check("rst.state", 64'(fetch_state),    64'(FETCH));
        check("rst.addr",  64'(bus.rom_addr),   64'd0);

        // Sequential fetch: one instruction per cycle from pc 0
        RESET          = 1'b0;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 28; k++) begin
            tick();
            check_head("seq", 32'(4 * k), k);
        end
        check("seq.state", 64'(fetch_state), 64'(FETCH));

        // Backpressure: head 108 held, queue fills, fetch freezes at pc 116
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_head("bp", 32'd108, 27);
            check("bp.state", 64'(fetch_state), 64'(STALL));
            check("bp.addr",  64'(bus.rom_addr), 64'd29);
        end
        check("bp.count", 64'(dut.q_count), 64'd2);
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_head("bp_rel", 32'(112 + 4 * k), 28 + k);
        end
        check("pre_redir.count", 64'(dut.q_count), 64'd2);

        // Redirect to misaligned 0x42 with a full queue and decode ready
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        tick();
        redirect_valid = 1'b0;
        check("redir.valid", 64'(bus.inst_valid), 64'd0);
        check("redir.addr",  64'(bus.rom_addr),   64'd16);
        check("redir.state", 64'(fetch_state),    64'(FETCH));
        tick();
        check_head("redir0", 32'h40, 16);
        tick();
        check_head("redir1", 32'h44, 17);

        // Halt for 4 cycles: queue drains, pc held at 0x48
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("halt.valid", 64'(bus.inst_valid), 64'd0);
            check("halt.state", 64'(fetch_state),    64'(HALT));
            check("halt.addr",  64'(bus.rom_addr),   64'd18);
        end
        halt = 1'b0;
        tick();
        check_head("resume0", 32'h48, 18);
        check("resume.state", 64'(fetch_state), 64'(FETCH));
        tick();
        check_head("resume1", 32'h4C, 19);

        // ROM wrap from the last word
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0FFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap.addr0", 64'(bus.rom_addr), 64'h3FF);
        tick();
        check_head("wrap0", 32'h0FFC, 1023);
        check("wrap.addr1", 64'(bus.rom_addr), 64'h000);
        tick();
        check_head("wrap1", 32'h1000, 0);

        // Mid-operation reset with two entries queued, redirect and ready high
        bus.inst_ready = 1'b0;
        tick();
        check("mid.count", 64'(dut.q_count), 64'd2);
        check_head("mid.head", 32'h1000, 0);
        RESET          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        bus.inst_ready = 1'b1;
        tick();
        check("mrst.valid", 64'(bus.inst_valid), 64'd0);
        check("mrst.data",  64'(bus.inst_data),  64'd0);
        check("mrst.pc",    64'(bus.inst_pc),    64'd0);
        check("mrst.state", 64'(fetch_state),    64'(FETCH));
        check("mrst.addr",  64'(bus.rom_addr),   64'd0);
        check("mrst.count", 64'(dut.q_count),    64'd0);
        RESET          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        check_head("post_rst", 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
